// File: rtl/mac_sign_restore_acc.sv
// mac_sign_restore_acc: post-multiplier sign restore and segmented accumulator.
// Stage 1 turns unsigned product magnitudes into two's-complement lane values.
// Stage 2 either loads or adds them into a 4x40-bit accumulator. In dual and
// quad modes the carry is allowed to cross the 40-bit segment boundaries.
module mac_sign_restore_acc #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_MULT_WIDTH = 2*MAC_MIN_WIDTH,
  parameter int MAC_ACC_WIDTH  = 2*MAC_MULT_WIDTH,
  parameter int MAC_INT_WIDTH  = 5*MAC_MIN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [MAC_CONF_WIDTH-1:0]     cfg,
  input  logic                          in_valid,
  input  logic                          acc_clr,
  input  logic [4*MAC_MULT_WIDTH-1:0]   prod_in,
  input  logic                          C0_neg,
  input  logic                          C1_neg,
  input  logic                          C2_neg,
  input  logic                          C3_neg,
  output logic                          out_valid,
  output logic [4*MAC_INT_WIDTH-1:0]    acc_out
);

  localparam int LW = MAC_INT_WIDTH;     // single-lane segment width
  localparam int DW = 2*MAC_INT_WIDTH;   // dual-lane width
  localparam int QW = 4*MAC_INT_WIDTH;   // full accumulator width
  localparam int MW = MAC_MULT_WIDTH;    // single-lane product width

  // MAC_ACC_WIDTH is kept only for interface compatibility; reject nonsense values.
  if (MAC_ACC_WIDTH < MAC_MULT_WIDTH) begin : g_param_check
    $error("MAC_ACC_WIDTH must not be smaller than MAC_MULT_WIDTH");
  end

  logic [3:0]                w_flag;
  logic [QW-1:0]             w_lane_val;
  logic [QW-1:0]             w_sum;
  logic                      w_chain;
  logic                      w_quad;
  logic                      w_load;

  logic                      r_s1_valid;
  logic [MAC_CONF_WIDTH-1:0] r_s1_cfg;
  logic                      r_s1_clr;
  logic [QW-1:0]             r_s1_val;
  logic [QW-1:0]             r_acc;
  logic [2:0]                r_last_cfg;   // {sign, mode[1:0]} of the last accumulated beat
  logic                      r_hist;       // an accumulated beat exists since reset
  logic                      r_out_valid;

  assign w_flag = {C3_neg, C2_neg, C1_neg, C0_neg};

  // Zero-extend each magnitude to its lane width and negate it when the lane is signed and flagged.
  always_comb begin
    w_lane_val = {QW{1'b0}};
    case (cfg[1:0])
      2'b01: begin
        for (int j = 0; j < 2; j++) begin
          w_lane_val[DW*j +: DW] = (cfg[3] && w_flag[2*j+1])
            ? ({DW{1'b0}} - DW'(prod_in[2*MW*j +: 2*MW]))
            : DW'(prod_in[2*MW*j +: 2*MW]);
        end
      end
      2'b10: begin
        w_lane_val = (cfg[3] && w_flag[3])
          ? ({QW{1'b0}} - QW'(prod_in))
          : QW'(prod_in);
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          w_lane_val[LW*i +: LW] = (cfg[3] && w_flag[i])
            ? ({LW{1'b0}} - LW'(prod_in[MW*i +: MW]))
            : LW'(prod_in[MW*i +: MW]);
        end
      end
    endcase
  end

  // Decode which segment boundaries the staged beat lets the carry cross.
  always_comb begin
    w_chain = 1'b0;
    w_quad  = 1'b0;
    case (r_s1_cfg[1:0])
      2'b01: begin
        w_chain = 1'b1;
        w_quad  = 1'b0;
      end
      2'b10: begin
        w_chain = 1'b1;
        w_quad  = 1'b1;
      end
      default: begin
        w_chain = 1'b0;
        w_quad  = 1'b0;
      end
    endcase
  end

  // Segmented add: 0->1 and 2->3 link in dual/quad, 1->2 links only in quad.
  always_comb begin
    logic [LW:0] v_seg;
    logic        v_cy;
    logic        v_cin;
    w_sum = {QW{1'b0}};
    v_seg = {(LW+1){1'b0}};
    v_cy  = 1'b0;
    v_cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        v_cin = 1'b0;
      end else if (i == 2) begin
        v_cin = w_quad & v_cy;
      end else begin
        v_cin = w_chain & v_cy;
      end
      v_seg = {1'b0, r_acc[LW*i +: LW]} + {1'b0, r_s1_val[LW*i +: LW]} + {{LW{1'b0}}, v_cin};
      w_sum[LW*i +: LW] = v_seg[LW-1:0];
      v_cy = v_seg[LW];
    end
  end

  // A beat starts a fresh result in MUL mode, on clear, on mode/sign change, or first after reset.
  always_comb begin
    if (!r_s1_cfg[2] || r_s1_clr || !r_hist) begin
      w_load = 1'b1;
    end else if ((r_s1_cfg[1:0] != r_last_cfg[1:0]) || (r_s1_cfg[3] != r_last_cfg[2])) begin
      w_load = 1'b1;
    end else begin
      w_load = 1'b0;
    end
  end

  // Stage 1: capture the beat's control and signed lane values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cfg   <= {MAC_CONF_WIDTH{1'b0}};
      r_s1_clr   <= 1'b0;
      r_s1_val   <= {QW{1'b0}};
    end else if (en) begin
      r_s1_valid <= in_valid;
      r_s1_cfg   <= cfg;
      r_s1_clr   <= acc_clr;
      r_s1_val   <= w_lane_val;
    end
  end

  // Stage 2: load or accumulate valid beats; bubbles leave the accumulator untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= {QW{1'b0}};
      r_last_cfg  <= 3'b000;
      r_hist      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_acc      <= w_load ? r_s1_val : w_sum;
        r_last_cfg <= {r_s1_cfg[3], r_s1_cfg[1:0]};
        r_hist     <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_mac_sign_restore_acc.sv
// Bench for mac_sign_restore_acc: directed vector table, hand-written stall and
// reset sequences, then random traffic against a lane-arithmetic reference model.
module tb_mac_sign_restore_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   cfg;
  logic         in_valid;
  logic         acc_clr;
  logic [63:0]  prod_in;
  logic [3:0]   neg;
  logic         out_valid;
  logic [159:0] acc_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mac_sign_restore_acc dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg), .in_valid(in_valid),
    .acc_clr(acc_clr), .prod_in(prod_in),
    .C0_neg(neg[0]), .C1_neg(neg[1]), .C2_neg(neg[2]), .C3_neg(neg[3]),
    .out_valid(out_valid), .acc_out(acc_out)
  );

  typedef struct {
    logic [3:0]   cfg;
    logic         clr;
    logic [63:0]  prod;
    logic [3:0]   neg;
    logic [159:0] exp;
  } vec_t;

  vec_t vt[13];

  // Reference model state: accumulator contents and the mode of the last beat.
  logic [159:0] m_acc;
  logic [2:0]   m_last;
  bit           m_hist;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic clr,
                       input logic [63:0] p, input logic [3:0] n);
    in_valid = v; cfg = c; acc_clr = clr; prod_in = p; neg = n;
  endtask

  // Applies one beat to the model using plain per-lane modular arithmetic.
  task automatic model_beat(input logic [3:0] c, input logic clr,
                            input logic [63:0] p, input logic [3:0] n);
    bit load;
    load = !c[2] || clr || !m_hist || ({c[3], c[1:0]} != m_last);
    if (c[1:0] == 2'b10) begin
      logic [159:0] v;
      v = {96'd0, p};
      if (c[3] && n[3]) v = -v;
      m_acc = load ? v : m_acc + v;
    end else if (c[1:0] == 2'b01) begin
      for (int j = 0; j < 2; j++) begin
        logic [79:0] v;
        v = {48'd0, p[32*j +: 32]};
        if (c[3] && n[2*j+1]) v = -v;
        m_acc[80*j +: 80] = load ? v : m_acc[80*j +: 80] + v;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [39:0] v;
        v = {24'd0, p[16*i +: 16]};
        if (c[3] && n[i]) v = -v;
        m_acc[40*i +: 40] = load ? v : m_acc[40*i +: 40] + v;
      end
    end
    m_last = {c[3], c[1:0]};
    m_hist = 1'b1;
  endtask

  initial begin
    logic         p1_v;
    logic [3:0]   p1_cfg;
    logic         p1_clr;
    logic [63:0]  p1_prod;
    logic [3:0]   p1_neg;
    logic         exp_ov;

    vt[0]  = '{4'b1100, 1'b0, 64'h000F, 4'b0001, {120'd0, 40'hFF_FFFF_FFF1}};
    vt[1]  = '{4'b1100, 1'b0, 64'h000F, 4'b0001, {120'd0, 40'hFF_FFFF_FFE2}};
    vt[2]  = '{4'b1001, 1'b0, 64'h0010, 4'b0010, {80'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFF0}};
    vt[3]  = '{4'b1001, 1'b0, 64'h0010, 4'b0010, {80'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFF0}};
    vt[4]  = '{4'b0110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, {96'd0, 64'hFFFF_FFFF_FFFF_FFFF}};
    vt[5]  = '{4'b0110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 160'h1_FFFF_FFFF_FFFF_FFFE};
    vt[6]  = '{4'b0100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, {4{40'h00_0000_FFFF}}};
    vt[7]  = '{4'b0100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, {4{40'h00_0001_FFFE}}};
    vt[8]  = '{4'b0100, 1'b1, 64'h0000_8000_0000_0000, 4'b0100, {40'd0, 40'h00_0000_8000, 80'd0}};
    vt[9]  = '{4'b1100, 1'b1, 64'h0, 4'b1111, 160'd0};
    vt[10] = '{4'b0101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000,
               {48'd0, 32'hFFFF_FFFF, 48'd0, 32'hFFFF_FFFF}};
    vt[11] = '{4'b0101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000,
               {80'h1_FFFF_FFFE, 80'h1_FFFF_FFFE}};
    vt[12] = '{4'b0100, 1'b1, 64'h0007, 4'b0000, {120'd0, 40'd7}};

    // Reset and idle state.
    rst = 1'b0; en = 1'b1;
    drive(1'b0, 4'b0000, 1'b0, 64'h0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_acc", acc_out, 160'd0);
    chk("reset_ov", {159'd0, out_valid}, 160'd0);
    @(negedge clk) rst = 1'b1;

    // Directed vectors, issued back to back; vector k is visible two edges later.
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k < 13) drive(1'b1, vt[k].cfg, vt[k].clr, vt[k].prod, vt[k].neg);
      else        drive(1'b0, 4'b0100, 1'b0, 64'h0, 4'b0000);
      @(posedge clk);
      #1;
      if (k >= 1) begin
        chk($sformatf("vec%0d_acc", k-1), acc_out, vt[k-1].exp);
        chk($sformatf("vec%0d_ov", k-1), {159'd0, out_valid}, 160'd1);
      end
    end
    @(posedge clk);
    #1;
    chk("bubble_ov", {159'd0, out_valid}, 160'd0);
    chk("bubble_hold", acc_out, {120'd0, 40'd7});

    // Stall: two beats in flight, three frozen cycles with junk on the inputs.
    @(negedge clk) drive(1'b1, 4'b0100, 1'b1, 64'h3, 4'b0000);
    @(negedge clk) drive(1'b1, 4'b0100, 1'b0, 64'h4, 4'b0000);
    @(posedge clk);
    #1;
    chk("stall_pre_acc", acc_out, {120'd0, 40'd3});
    @(negedge clk);
    en = 1'b0;
    drive(1'b1, 4'b0100, 1'b1, 64'h0100, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      chk("stall_acc", acc_out, {120'd0, 40'd3});
      chk("stall_ov", {159'd0, out_valid}, 160'd1);
    end
    @(negedge clk);
    en = 1'b1;
    drive(1'b0, 4'b0100, 1'b0, 64'h0, 4'b0000);
    @(posedge clk);
    #1;
    chk("stall_post_acc", acc_out, {120'd0, 40'd7});
    chk("stall_post_ov", {159'd0, out_valid}, 160'd1);
    @(posedge clk);
    #1;
    chk("stall_end_ov", {159'd0, out_valid}, 160'd0);
    chk("stall_end_acc", acc_out, {120'd0, 40'd7});

    // Reset between edges with two beats in flight.
    @(negedge clk) drive(1'b1, 4'b0100, 1'b0, 64'h9, 4'b0000);
    @(negedge clk) drive(1'b1, 4'b0100, 1'b0, 64'h9, 4'b0000);
    @(posedge clk);
    #1;
    chk("pre_rst_acc", acc_out, {120'd0, 40'h10});
    @(negedge clk);
    drive(1'b0, 4'b0100, 1'b0, 64'h0, 4'b0000);
    #2 rst = 1'b0;
    #1;
    chk("midrst_acc", acc_out, 160'd0);
    chk("midrst_ov", {159'd0, out_valid}, 160'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ov", {159'd0, out_valid}, 160'd0);
    @(negedge clk) drive(1'b1, 4'b0100, 1'b0, 64'h5, 4'b0000);
    @(negedge clk) drive(1'b0, 4'b0100, 1'b0, 64'h0, 4'b0000);
    @(posedge clk);
    #1;
    chk("first_after_rst_acc", acc_out, {120'd0, 40'd5});
    chk("first_after_rst_ov", {159'd0, out_valid}, 160'd1);

    // Random traffic against the reference model.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    m_acc = 160'd0; m_last = 3'b000; m_hist = 1'b0;
    p1_v = 1'b0; p1_cfg = 4'b0000; p1_clr = 1'b0; p1_prod = 64'h0; p1_neg = 4'b0000;
    exp_ov = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [63:0] p;
      @(negedge clk);
      en = ($urandom_range(0, 9) < 8);
      p = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) p = 64'hFFFF_FFFF_FFFF_FFFF;
      drive($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0, p, 4'($urandom_range(0, 15)));
      @(posedge clk);
      if (en) begin
        if (p1_v) model_beat(p1_cfg, p1_clr, p1_prod, p1_neg);
        exp_ov  = p1_v;
        p1_v    = in_valid;
        p1_cfg  = cfg;
        p1_clr  = acc_clr;
        p1_prod = prod_in;
        p1_neg  = neg;
      end
      #1;
      chk("rnd_ov", {159'd0, out_valid}, {159'd0, exp_ov});
      chk("rnd_acc", acc_out, m_acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_sign_restore_acc.md
Name: mac_sign_restore_acc

Overview:
Post-multiplier stage of the MAC datapath. It takes the unsigned product magnitudes from the lane multiplier and the per-lane C*_neg flags from the operand negator. It restores the two's-complement sign per lane according to cfg, and either loads (MUL mode) or accumulates (MAC mode) into a segmented 4×MAC_INT_WIDTH accumulator. The block has a two-stage pipeline with an enable-based stall.

Parameters:
MAC_CONF_WIDTH, 4, cfg width: [3] signed, [2] mac(1)/mul(0), [1:0] 01=dual, 10=quad, else single
MAC_MIN_WIDTH, 8, base operand lane width
MAC_MULT_WIDTH, 2*MAC_MIN_WIDTH, per-lane product width in single mode
MAC_ACC_WIDTH, 2*MAC_MULT_WIDTH, reserved; not used for internal sizing
MAC_INT_WIDTH, 5*MAC_MIN_WIDTH, accumulator segment width (40)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  pipeline enable; 0 freezes every register
cfg  in  MAC_CONF_WIDTH  mode, sampled with each beat
in_valid  in  1  prod_in/C*_neg valid this cycle
acc_clr  in  1  next accumulate in stage 2 starts from zero
prod_in  in  4*MAC_MULT_WIDTH  unsigned magnitudes; single: 4×16 at [16i+:16]; dual: 2×32 at [32j+:32]; quad: 1×64
C0_neg, C1_neg, C2_neg, C3_neg  in  1 each  negator sign flags
out_valid  out  1  acc_out updated by a valid beat
acc_out  out  4*MAC_INT_WIDTH  single: 4×40 at [40i+:40]; dual: 2×80; quad: 1×160

Behaviour:
- Reset (rst=0, async): all pipe registers, the accumulator, out_valid and stored cfg go to 0. acc_out=0.
- en=0: no register changes. Valid beats are neither lost nor duplicated.
- Stage 1 (registered when en=1):
  - Captures cfg, acc_clr and in_valid.
  - Computes the signed lane value: magnitude zero-extended to the segment width (40/80/160 bits), then two's-complement negated if cfg[3]=1 and the lane flag is set.
  - Lane flags: single lane i uses Ci_neg; dual low uses C1_neg, high uses C3_neg; quad uses C3_neg.
  - cfg[3]=0 ignores all flags.
  - Negating a zero magnitude yields 0.
- Stage 2 (registered when en=1 and stage-1 valid):
  - Segmented 160-bit add. Carry crosses the 40-bit boundaries 0→1 and 2→3 in dual and quad modes, and boundary 1→2 in quad mode only.
  - Load (acc ← value) when any of the following holds: cfg[2]=0, the staged acc_clr=1, or the staged cfg[1:0] or cfg[3] differs from the cfg of the last accumulated beat.
  - Otherwise acc ← acc + value, wrapping modulo each segment width with no saturation.
- out_valid is registered: 1 for one enabled cycle per accepted beat.
- Latency: 2 enabled cycles from in_valid to out_valid/acc_out.
- Back-to-back beats have throughput 1/cycle. A mode change between consecutive beats is legal because each beat carries its own staged cfg.
- Stage-1 invalid bubble: acc holds and out_valid=0.
- Reset mid-pipeline discards in-flight beats. The first beat after reset loads.

Test Plan:
1. Single signed MAC. cfg=4'b1100, prod_in lane0=16'd15, C0_neg=1, other lanes 0, two beats → acc_out[39:0] reads 40'hFFFFFFFFF1 two cycles after beat 1, then 40'hFFFFFFFFE2 after beat 2. out_valid pulses twice.
2. Dual signed MUL. cfg=4'b1001, prod_in[31:0]=32'h10, C1_neg=1, C0_neg=0 → acc_out[79:0] = -16 (80'hFF..F0); acc_out[159:80]=0; a repeat beat gives the same value (no accumulation).
3. Quad carry chain. cfg=4'b0110 unsigned MAC, prod_in=64'hFFFFFFFFFFFFFFFF twice → acc_out = 160'h1_FFFFFFFF_FFFFFFFE, with carry propagated across segments. The same stimulus in single mode gives each lane 40'h1FFFE with no cross-lane carry.
4. Unsigned ignores flags. cfg=4'b0100, lane2=16'h8000, C2_neg=1 → acc_out[119:80]=40'h0000008000.
5. Stall and clear. Hold en=0 for 3 cycles mid-stream → acc_out and out_valid frozen, no beat lost. A beat with acc_clr=1 and value 7 → lane0=7 regardless of prior contents.
6. Reset mid-op. Assert rst=0 asynchronously between clock edges with two beats in flight → acc_out=0 and out_valid=0 immediately. After release, the first beat (5) reads 5.
